// File: rtl/ubus_arbiter.sv
// ubus_arbiter: central UBUS arbiter and phase sequencer.
// Walks the bus through ARB / NOOP / ADDR / DATA phases, picks one requester per
// arbitration cycle (round-robin or fixed priority) and recovers from a stalled
// slave with a wait-state watchdog. Grants change on the falling edge so they are
// stable across the ARB->ADDR rising edge; everything else moves on the rising edge.
module ubus_arbiter #(
    parameter int NUM_MASTERS   = 4,
    parameter int PRIORITY_MODE = 0,
    parameter int TIMEOUT       = 16
) (
    input  logic                   ubus_clock,
    input  logic                   ubus_reset,
    input  logic [NUM_MASTERS-1:0] ubus_req,
    output logic [NUM_MASTERS-1:0] ubus_gnt,
    output logic                   ubus_start,
    input  logic                   ubus_bip,
    input  logic                   ubus_wait,
    input  logic                   ubus_error,
    output tri logic               ubus_read,
    output tri logic               ubus_write,
    output logic [2:0]             arb_owner,
    output logic                   arb_busy,
    output logic                   arb_timeout
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ARB  = 3'd1,
        S_NOOP = 3'd2,
        S_ADDR = 3'd3,
        S_DATA = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [7:0]             wd_q, wd_d;
    logic                   timeout_q, timeout_d;
    logic                   noop_q, noop_d;
    logic [2:0]             owner_q, owner_d;

    logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
    logic [2:0]             gnt_idx_q, gnt_idx_d;
    logic [2:0]             last_q, last_d;

    logic [NUM_MASTERS-1:0] above_mask;
    logic [NUM_MASTERS-1:0] upper_req;
    logic [2:0]             pick_idx;
    logic                   pick_valid;

    // Index of the lowest set bit of a request vector (0 when the vector is empty).
    function automatic logic [2:0] lowest_index(input logic [NUM_MASTERS-1:0] v);
        logic [2:0] idx;
        idx = '0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

    // Winner selection: round-robin prefers requesters above the last winner, wrapping to the bottom.
    always_comb begin
        above_mask = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            above_mask[i] = (3'(i) > last_q);
        end
        upper_req  = ubus_req & above_mask;
        pick_valid = |ubus_req;
        if (PRIORITY_MODE == 1) begin
            pick_idx = lowest_index(ubus_req);
        end else if (|upper_req) begin
            pick_idx = lowest_index(upper_req);
        end else begin
            pick_idx = lowest_index(ubus_req);
        end
    end

    // Falling-edge grant update: grant during ARB, clear as soon as the start marker drops.
    always_comb begin
        gnt_d     = '0;
        gnt_idx_d = gnt_idx_q;
        last_d    = last_q;
        if (ubus_start && pick_valid) begin
            gnt_d     = NUM_MASTERS'(1) << pick_idx;
            gnt_idx_d = pick_idx;
            if (PRIORITY_MODE == 0) begin
                last_d = pick_idx;
            end
        end
    end

    // Grant and round-robin pointer registers; reset points the pointer at the top so master 0 goes first.
    always_ff @(negedge ubus_clock or posedge ubus_reset) begin
        if (ubus_reset) begin
            gnt_q     <= '0;
            gnt_idx_q <= '0;
            last_q    <= 3'(NUM_MASTERS - 1);
        end else begin
            gnt_q     <= gnt_d;
            gnt_idx_q <= gnt_idx_d;
            last_q    <= last_d;
        end
    end

    // Phase sequencing and watchdog; a normal completion always beats a watchdog abort.
    always_comb begin
        state_d   = state_q;
        wd_d      = wd_q;
        timeout_d = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_ARB;
            S_ARB:  state_d = (|gnt_q) ? S_ADDR : S_NOOP;
            S_NOOP: state_d = S_ARB;
            S_ADDR: begin
                state_d = S_DATA;
                wd_d    = '0;
            end
            S_DATA: begin
                if (ubus_error || (!ubus_bip && !ubus_wait)) begin
                    state_d = S_ARB;
                    wd_d    = '0;
                end else if (ubus_wait) begin
                    if (wd_q + 8'd1 == 8'(TIMEOUT)) begin
                        state_d   = S_ARB;
                        timeout_d = 1'b1;
                        wd_d      = '0;
                    end else begin
                        wd_d = wd_q + 8'd1;
                    end
                end else begin
                    wd_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Phase-derived outputs and the values captured at the next rising edge.
    always_comb begin
        ubus_start = (state_q == S_ARB);
        arb_busy   = (state_q == S_ADDR) || (state_q == S_DATA);
        noop_d     = (state_q == S_ARB) && (gnt_q == '0);
        owner_d    = ((state_q == S_ARB) && (|gnt_q)) ? gnt_idx_q : owner_q;
    end

    // Rising-edge registers for phase, watchdog, strobe enable, owner and timeout pulse.
    always_ff @(posedge ubus_clock or posedge ubus_reset) begin
        if (ubus_reset) begin
            state_q   <= S_IDLE;
            wd_q      <= '0;
            timeout_q <= 1'b0;
            noop_q    <= 1'b0;
            owner_q   <= '0;
        end else begin
            state_q   <= state_d;
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
            noop_q    <= noop_d;
            owner_q   <= owner_d;
        end
    end

    assign ubus_gnt    = gnt_q;
    assign arb_owner   = owner_q;
    assign arb_timeout = timeout_q;
    assign ubus_read   = noop_q ? 1'b0 : 1'bz;
    assign ubus_write  = noop_q ? 1'b0 : 1'bz;

endmodule
